bus_alu_unit: RTL and testbench

BUS_ALU_UNIT -- requirements
Module: bus_alu_unit

---
 rtl/bus_alu_unit.sv | 177 +++++++++++++++++
 tb/tb_bus_alu_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_alu_unit.sv
// Bus-attached ALU: operand regs A/B loaded from bus_in, result register driven onto bus_out.
// Latency: ops 0-9 and illegal ops finish in 1 cycle; MUL/DIV/REM take WIDTH cycles (busy high).
// Backpressure: start is accepted only in IDLE; a start while busy is dropped with no effect.
module bus_alu_unit #(
  parameter int WIDTH     = 16,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             alu_a,
  input  logic             alu_b,
  input  logic [3:0]       sel,
  input  logic             start,
  input  logic             alu_out_en,
  output logic [WIDTH-1:0] bus_out,
  output logic             busy,
  output logic             done,
  output logic [4:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic [4:0]         flags_q;
  logic               done_q;
  logic [3:0]         w_op;
  logic [WIDTH-1:0]   w_b;
  logic [2*WIDTH-1:0] mp;        // shift-add product: high half accumulates, low half holds multiplier
  logic [WIDTH-1:0]   dq, dr;    // restoring divider quotient/dividend and partial remainder
  logic [CW-1:0]      cnt;

  logic               accept, is_muldiv, finish;
  logic [WIDTH-1:0]   sc_res;
  logic [4:0]         sc_flags;
  logic [WIDTH:0]     add_s, sub_s;
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mp_nx;
  logic [WIDTH-1:0]   dq_nx, dr_nx;
  logic [WIDTH-1:0]   md_res;
  logic [4:0]         md_flags;
  logic               unused_bits;

  assign busy    = (state_q == BUSY);
  assign done    = done_q;
  assign flags   = flags_q;
  assign bus_out = alu_out_en ? res_q : {WIDTH{1'bz}};

  assign accept    = (state_q == IDLE) && start;
  assign is_muldiv = MULDIV_EN && (sel >= 4'hA) && (sel <= 4'hC);
  assign finish    = (state_q == BUSY) && (cnt == CW'(WIDTH - 1));

  // Next-state logic: multi-cycle ops park in BUSY for WIDTH edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_muldiv) state_d = BUSY;
      BUSY: if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle ops computed from the operand values held before the accepting edge.
  always_comb begin
    logic e, v, c;
    add_s  = {1'b0, a_q} + {1'b0, b_q};
    sub_s  = {1'b0, a_q} - {1'b0, b_q};
    sc_res = '0;
    e      = 1'b0;
    v      = 1'b0;
    c      = 1'b0;
    case (sel)
      4'h0: begin
        sc_res = add_s[WIDTH-1:0];
        c      = add_s[WIDTH];
        v      = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'h1: begin
        sc_res = sub_s[WIDTH-1:0];
        c      = sub_s[WIDTH];
        v      = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_s[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'h2: sc_res = a_q & b_q;
      4'h3: sc_res = a_q | b_q;
      4'h4: sc_res = a_q ^ b_q;
      4'h5: sc_res = ~a_q;
      4'h6: begin sc_res = {a_q[WIDTH-2:0], 1'b0}; c = a_q[WIDTH-1]; end
      4'h7: begin sc_res = {1'b0, a_q[WIDTH-1:1]}; c = a_q[0]; end
      4'h8: sc_res = a_q;
      4'h9: sc_res = b_q;
      default: e = 1'b1;   // illegal (including MUL/DIV/REM when disabled): result stays 0
    endcase
    sc_flags = {e, v, c, sc_res[WIDTH-1], (sc_res == '0)};
  end

  // One shift-add and one restoring-divide step; the final step feeds the result directly.
  always_comb begin
    mul_sum   = {1'b0, mp[2*WIDTH-1:WIDTH]} + (mp[0] ? {1'b0, w_b} : '0);
    mp_nx     = {mul_sum, mp[WIDTH-1:1]};
    div_trial = {dr, dq[WIDTH-1]};
    div_diff  = div_trial - {1'b0, w_b};
    div_ge    = (div_trial >= {1'b0, w_b});
    // Partial remainder always fits WIDTH bits (it stays below B, or is a prefix of A when B=0).
    dr_nx     = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    dq_nx     = {dq[WIDTH-2:0], div_ge};
    md_res    = '0;
    md_flags  = '0;
    case (w_op)
      4'hA: begin
        md_res      = mp_nx[WIDTH-1:0];
        md_flags[2] = |mp_nx[2*WIDTH-1:WIDTH];
      end
      4'hB: begin md_res = dq_nx; md_flags[4] = (w_b == '0); end
      default: begin md_res = dr_nx; md_flags[4] = (w_b == '0); end
    endcase
    md_flags[1] = md_res[WIDTH-1];
    md_flags[0] = (md_res == '0);
  end

  assign unused_bits = ^{div_diff[WIDTH], div_trial[WIDTH]};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand, working, result and flag registers; done pulses one cycle per completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      w_op    <= '0;
      w_b     <= '0;
      mp      <= '0;
      dq      <= '0;
      dr      <= '0;
      cnt     <= '0;
    end else begin
      done_q <= 1'b0;
      if (alu_a) a_q <= bus_in;
      if (alu_b) b_q <= bus_in;
      if (accept) begin
        if (is_muldiv) begin
          w_op <= sel;
          w_b  <= b_q;
          mp   <= {{WIDTH{1'b0}}, a_q};
          dq   <= a_q;
          dr   <= '0;
          cnt  <= '0;
        end else begin
          res_q   <= sc_res;
          flags_q <= sc_flags;
          done_q  <= 1'b1;
        end
      end else if (state_q == BUSY) begin
        mp  <= mp_nx;
        dq  <= dq_nx;
        dr  <= dr_nx;
        cnt <= cnt + 1'b1;
        if (finish) begin
          res_q   <= md_res;
          flags_q <= md_flags;
          done_q  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_alu_unit.sv
module tb_bus_alu_unit;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  bus_in;
  logic          alu_a, alu_b, start, alu_out_en;
  logic [3:0]    sel;
  logic [W-1:0]  bus_out;
  logic          busy, done;
  logic [4:0]    flags;

  int n_cmp  = 0;
  int n_fail = 0;

  bus_alu_unit #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .alu_a(alu_a), .alu_b(alu_b),
    .sel(sel), .start(start), .alu_out_en(alu_out_en), .bus_out(bus_out),
    .busy(busy), .done(done), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference from the arithmetic definitions: flags {E,V,C,N,Z}.
  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic [4:0] fl, output int lat);
    longint ua, ub, s;
    int sa, sb, ss;
    logic e, v, c;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    e = 0; v = 0; c = 0; r = 0; lat = 0;
    case (op)
      0: begin s = ua + ub; r = 16'(s); c = (s > 65535); ss = sa + sb; v = (ss > 32767) || (ss < -32768); end
      1: begin s = ua - ub; r = 16'(s); c = (ua < ub); ss = sa - sb; v = (ss > 32767) || (ss < -32768); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: begin s = ua * 2; r = 16'(s); c = (s > 65535); end
      7: begin r = 16'(ua / 2); c = (ua % 2) == 1; end
      8: r = a;
      9: r = b;
      10: begin s = ua * ub; r = 16'(s); c = (s / 65536) != 0; lat = 16; end
      11: begin lat = 16; if (ub == 0) begin r = 16'hFFFF; e = 1; end else r = 16'(ua / ub); end
      12: begin lat = 16; if (ub == 0) begin r = a; e = 1; end else r = 16'(ua % ub); end
      default: e = 1;
    endcase
    fl = {e, v, c, r[15], (r == 0)};
  endtask

  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic [4:0] fl, output int lat);
    bus_in = a; alu_a = 1; tick();
    alu_a = 0; bus_in = b; alu_b = 1; tick();
    alu_b = 0; sel = op; start = 1; tick();
    start = 0; lat = 0;
    while (!done && lat < 40) begin
      if (busy && done) chk("done_while_busy", 1, 0);
      tick();
      lat++;
    end
    if (!done) chk("op_timeout", 0, 1);
    chk("busy_at_done", busy, 0);
    res = bus_out;
    fl  = flags;
  endtask

  initial begin
    vec_t vecs[$];
    logic [15:0] r, er, a, b;
    logic [4:0]  f, ef;
    logic [3:0]  op;
    int lat, elat, seen;

    reset = 0; bus_in = 0; alu_a = 0; alu_b = 0; sel = 0; start = 0; alu_out_en = 1;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 0);
    chk("rst_bus_out", bus_out, 0);
    @(negedge clk); reset = 1;
    tick();

    vecs.push_back('{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 5'b00101, 0});
    vecs.push_back('{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 5'b01000, 0});
    vecs.push_back('{4'h2, 16'hF0F0, 16'h3C3C, 16'h3030, 5'b00000, 0});
    vecs.push_back('{4'h3, 16'hF000, 16'h000F, 16'hF00F, 5'b00010, 0});
    vecs.push_back('{4'h4, 16'hAAAA, 16'hAAAA, 16'h0000, 5'b00001, 0});
    vecs.push_back('{4'h5, 16'h00FF, 16'h1234, 16'hFF00, 5'b00010, 0});
    vecs.push_back('{4'h6, 16'h8001, 16'h0000, 16'h0002, 5'b00100, 0});
    vecs.push_back('{4'h7, 16'h0003, 16'h0000, 16'h0001, 5'b00100, 0});
    vecs.push_back('{4'h9, 16'h1111, 16'h8000, 16'h8000, 5'b00010, 0});
    vecs.push_back('{4'hA, 16'h0123, 16'h0010, 16'h1230, 5'b00000, 16});
    vecs.push_back('{4'hA, 16'h1000, 16'h0100, 16'h0000, 5'b00101, 16});
    vecs.push_back('{4'hB, 16'h0064, 16'h0007, 16'h000E, 5'b00000, 16});
    vecs.push_back('{4'hC, 16'h0064, 16'h0007, 16'h0002, 5'b00000, 16});
    vecs.push_back('{4'hB, 16'h0064, 16'h0000, 16'hFFFF, 5'b10010, 16});
    vecs.push_back('{4'hC, 16'h0064, 16'h0000, 16'h0064, 5'b10000, 16});
    vecs.push_back('{4'hE, 16'h1234, 16'h5678, 16'h0000, 5'b10001, 0});

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat);
      chk($sformatf("vec%0d_res", i), r, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), f, vecs[i].fl);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // SUB with a same-edge load of A, then PASS A accepted in the done cycle.
    bus_in = 16'h8000; alu_a = 1; tick();
    alu_a = 0; bus_in = 16'h0001; alu_b = 1; tick();
    alu_b = 0; bus_in = 16'h0000; alu_a = 1; sel = 4'h1; start = 1; tick();
    alu_a = 0;
    chk("sub_same_edge_done", done, 1);
    chk("sub_same_edge_res", bus_out, 16'h7FFF);
    chk("sub_same_edge_flags", flags, 5'b01000);
    sel = 4'h8; start = 1; tick(); start = 0;
    chk("b2b_done", done, 1);
    chk("b2b_pass_a_res", bus_out, 16'h0000);
    chk("b2b_pass_a_flags", flags, 5'b00001);

    // MUL with an ignored start during busy cycle 3.
    bus_in = 16'h0123; alu_a = 1; tick();
    alu_a = 0; bus_in = 16'h0010; alu_b = 1; tick();
    alu_b = 0; sel = 4'hA; start = 1; tick(); start = 0;
    for (int i = 1; i < 16; i++) begin
      if (i == 3) begin sel = 4'h0; start = 1; end
      chk($sformatf("mul_busy_c%0d", i), {busy, done}, 2'b10);
      tick();
      start = 0;
    end
    chk("mul_busy_c16", {busy, done}, 2'b10);
    tick();
    chk("mul_done", {busy, done}, 2'b01);
    chk("mul_res", bus_out, 16'h1230);
    chk("mul_flags", flags, 5'b00000);
    tick();
    chk("mul_no_extra_done", done, 0);
    chk("mul_res_hold", bus_out, 16'h1230);

    // Reset in the middle of a MUL.
    do_op(4'h0, 16'hFFFF, 16'h0001, r, f, lat);
    bus_in = 16'h0123; alu_a = 1; tick();
    alu_a = 0; bus_in = 16'h0010; alu_b = 1; tick();
    alu_b = 0; sel = 4'hA; start = 1; tick(); start = 0;
    repeat (4) tick();
    chk("pre_rst_busy", busy, 1);
    #2 reset = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_bus_out", bus_out, 0);
    @(negedge clk); reset = 1;
    seen = 0;
    repeat (20) begin tick(); if (done) seen++; end
    chk("midrst_no_done", seen, 0);
    chk("midrst_res_zero", bus_out, 0);
    do_op(4'h0, 16'h0003, 16'h0004, r, f, lat);
    chk("post_rst_add_res", r, 16'h0007);
    chk("post_rst_add_flags", f, 5'b00000);
    chk("post_rst_add_lat", lat, 0);

    // Randomized ops against the reference.
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      model(op, a, b, er, ef, elat);
      do_op(op, a, b, r, f, lat);
      chk($sformatf("rnd%0d_op%0h_res", i, op), r, er);
      chk($sformatf("rnd%0d_op%0h_flags", i, op), f, ef);
      chk($sformatf("rnd%0d_op%0h_lat", i, op), lat, elat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
